// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode constants, the format-class
// enum, the occupancy-state enum and the decoded bundle held in each slot.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    ITYPE_R = 3'd0,
    ITYPE_I = 3'd1,
    ITYPE_S = 3'd2,
    ITYPE_B = 3'd3,
    ITYPE_U = 3'd4,
    ITYPE_J = 3'd5
  } itype_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  // XLEN-independent part of a decoded instruction; pc and imm travel alongside.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    itype_t     itype;
    logic       illegal;
  } bundle_t;

  // True when the opcode belongs to the supported base set for the datapath width.
  function automatic logic opcode_known(input logic [6:0] op, input logic rv64);
    logic known;
    case (op)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
      OPC_OP_IMM_32, OPC_OP_32:                           known = rv64;
      default:                                            known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational format classifier and immediate generator.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output itype_t          itype,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Map the opcode onto its format class; anything unrecognised decodes as R.
  always_comb begin
    itype = ITYPE_R;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: itype = ITYPE_I;
      OPC_STORE:                                               itype = ITYPE_S;
      OPC_BRANCH:                                              itype = ITYPE_B;
      OPC_LUI, OPC_AUIPC:                                      itype = ITYPE_U;
      OPC_JAL:                                                 itype = ITYPE_J;
      OPC_OP_IMM_32: if (XLEN == 64)                           itype = ITYPE_I;
      default:                                                 itype = ITYPE_R;
    endcase
  end

  // Assemble the 32-bit immediate for the class; R reuses the I layout.
  always_comb begin
    imm32 = {{20{instr[31]}}, instr[31:20]};
    case (itype)
      ITYPE_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ITYPE_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ITYPE_U: imm32 = {instr[31:12], 12'b0};
      ITYPE_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // Every class, U included, sign-extends from bit 31 to the datapath width.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode stage with a two-entry (output + skid) valid/ready buffer.
// Optional: define DECODE_ILLEGAL_CHECK_EN to flag unrecognised instructions.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      itype,
  output logic            illegal
);

  itype_t          dec_itype;
  logic [XLEN-1:0] dec_imm;
  bundle_t         dec;

  occ_t            state_q, state_d;
  bundle_t         out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q, out_imm_q, skid_imm_q;
  logic            in_fire, out_fire;
  logic            load_out, load_skid, move_skid;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .itype (dec_itype),
    .imm   (dec_imm)
  );

  // Slice the raw fields and attach class and legality to the incoming word.
  always_comb begin
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];
    dec.itype  = dec_itype;
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (in_instr[1:0] != 2'b11) || !opcode_known(in_instr[6:0], XLEN == 64)
                  || (in_instr == 32'h0000_0000) || (in_instr == 32'hFFFF_FFFF);
`else
    dec.illegal = 1'b0;
`endif
  end

  // NOTE: rst is folded in combinationally so in_ready reads 0 for the whole
  // reset pulse and 1 as soon as it drops; out_ready never reaches it.
  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign load_out  = in_fire && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_fire));
  assign load_skid = in_fire && (state_q == ST_ONE) && !out_fire;
  assign move_skid = out_fire && (state_q == ST_FULL);

  // Occupancy next-state; flush wins over any transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Output and skid slots; the skid only fills when the output slot is stalled.
  // NOTE: both slots are reset because the data outputs must read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_pc_q   <= '0;
      skid_pc_q  <= '0;
      out_imm_q  <= '0;
      skid_imm_q <= '0;
    end else begin
      if (load_out) begin
        out_q     <= dec;
        out_pc_q  <= in_pc;
        out_imm_q <= dec_imm;
      end else if (move_skid) begin
        out_q     <= skid_q;
        out_pc_q  <= skid_pc_q;
        out_imm_q <= skid_imm_q;
      end
      if (load_skid) begin
        skid_q     <= dec;
        skid_pc_q  <= in_pc;
        skid_imm_q <= dec_imm;
      end
    end
  end

  assign out_pc  = out_pc_q;
  assign imm     = out_imm_q;
  assign opcode  = out_q.opcode;
  assign rd      = out_q.rd;
  assign funct3  = out_q.funct3;
  assign rs1     = out_q.rs1;
  assign rs2     = out_q.rs2;
  assign funct7  = out_q.funct7;
  assign itype   = out_q.itype;
  assign illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: XLEN=32 and XLEN=64 instances,
// directed vectors plus randomized traffic against a queue-based model.
module tb_decode_stage;

  logic        clk, rst;
  // XLEN=32 instance
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, itype;
  // XLEN=64 instance
  logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready, w_illegal;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_pc, w_out_pc, w_imm;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3, w_itype;

  int checks = 0;
  int errors = 0;

  logic [99:0]  obs32;
  logic [163:0] obs64;
  assign obs32 = {out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, itype, illegal};
  assign obs64 = {w_out_pc, w_opcode, w_rd, w_funct3, w_rs1, w_rs2, w_funct7, w_imm, w_itype, w_illegal};

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .itype(itype), .illegal(illegal)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
    .in_pc(w_in_pc), .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_pc(w_out_pc), .opcode(w_opcode), .rd(w_rd), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2),
    .funct7(w_funct7), .imm(w_imm), .itype(w_itype), .illegal(w_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_itype(input logic [31:0] instr, input bit rv64);
    int op;
    op = int'(instr & 32'h7F);
    case (op)
      'h03, 'h13, 'h67, 'h0F, 'h73: return 1;
      'h23:                         return 2;
      'h63:                         return 3;
      'h37, 'h17:                   return 4;
      'h6F:                         return 5;
      'h1B:                         return rv64 ? 1 : 0;
      default:                      return 0;
    endcase
  endfunction

  function automatic longint model_imm(input logic [31:0] instr, input int cls);
    int     s;
    longint sl;
    s  = instr;
    sl = s;
    case (cls)
      2: return (sl >>> 25) * 32 + longint'((instr >> 7) & 32'h1F);
      3: return (sl >>> 31) * 4096 + longint'((instr >> 7) & 1) * 2048
                + longint'((instr >> 25) & 32'h3F) * 32 + longint'((instr >> 8) & 32'hF) * 2;
      4: return (sl >>> 12) * 4096;
      5: return (sl >>> 31) * 1048576 + longint'((instr >> 12) & 32'hFF) * 4096
                + longint'((instr >> 20) & 1) * 2048 + longint'((instr >> 21) & 32'h3FF) * 2;
      default: return sl >>> 20;
    endcase
  endfunction

  function automatic logic exp_illegal(input logic [31:0] instr, input bit rv64);
`ifdef DECODE_ILLEGAL_CHECK_EN
    int  op;
    bit  known;
    op = int'(instr & 32'h7F);
    known = (op == 'h03 || op == 'h0F || op == 'h13 || op == 'h17 || op == 'h23 ||
             op == 'h33 || op == 'h37 || op == 'h63 || op == 'h67 || op == 'h6F ||
             op == 'h73 || (rv64 && (op == 'h1B || op == 'h3B)));
    return ((instr & 3) != 3) || !known || instr == 32'h0 || instr == 32'hFFFF_FFFF;
`else
    return 1'b0 & instr[0] & rv64;
`endif
  endfunction

  function automatic logic [99:0] exp32(input logic [31:0] instr, input logic [31:0] pc);
    int     cls;
    longint im;
    logic [63:0] imv;
    cls = model_itype(instr, 1'b0);
    im  = model_imm(instr, cls);
    imv = im;
    return {pc, 7'(instr & 32'h7F), 5'(instr >> 7), 3'(instr >> 12), 5'(instr >> 15),
            5'(instr >> 20), 7'(instr >> 25), imv[31:0], 3'(cls), exp_illegal(instr, 1'b0)};
  endfunction

  function automatic logic [163:0] exp64(input logic [31:0] instr, input logic [63:0] pc);
    int     cls;
    longint im;
    cls = model_itype(instr, 1'b1);
    im  = model_imm(instr, cls);
    return {pc, 7'(instr & 32'h7F), 5'(instr >> 7), 3'(instr >> 12), 5'(instr >> 15),
            5'(instr >> 20), 7'(instr >> 25), 64'(im), 3'(cls), exp_illegal(instr, 1'b1)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                              7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 4) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Push one word through both empty instances; outputs are valid on return.
  task automatic send_both(input logic [31:0] instr, input logic [63:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc[31:0]; out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_instr = instr; w_in_pc = pc; w_out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; w_in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, obs32} !== '0) begin
      errors++; $display("FAIL reset32: got %h required 0", {out_valid, in_ready, obs32});
    end
    checks++;
    if ({w_out_valid, w_in_ready, obs64} !== '0) begin
      errors++; $display("FAIL reset64: got %h required 0", {w_out_valid, w_in_ready, obs64});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || w_in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b/%b out_valid=%b required 1/1/0",
                         in_ready, w_in_ready, out_valid);
    end
  endtask

  task automatic check_both(input string name, input logic [31:0] instr, input logic [63:0] pc);
    checks++;
    if (out_valid !== 1'b1 || obs32 !== exp32(instr, pc[31:0])) begin
      errors++; $display("FAIL %s_x32: valid=%b got %h required %h", name, out_valid, obs32,
                         exp32(instr, pc[31:0]));
    end
    checks++;
    if (w_out_valid !== 1'b1 || obs64 !== exp64(instr, pc)) begin
      errors++; $display("FAIL %s_x64: valid=%b got %h required %h", name, w_out_valid, obs64,
                         exp64(instr, pc));
    end
  endtask

  task automatic test_vectors();
    send_both(32'hFFF00093, 64'h100);
    checks++;
    if (out_valid !== 1'b1 || rd !== 5'd1 || itype !== 3'd1 || imm !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL addi: valid=%b rd=%0d itype=%0d imm=%h required 1/1/1/ffffffff",
                         out_valid, rd, itype, imm);
    end
    check_both("addi", 32'hFFF00093, 64'h100);

    send_both(32'h00112623, 64'h104);
    checks++;
    if (itype !== 3'd2 || rs1 !== 5'd2 || rs2 !== 5'd1 || imm !== 32'h0000000C) begin
      errors++; $display("FAIL sw: itype=%0d rs1=%0d rs2=%0d imm=%h required 2/2/1/0000000c",
                         itype, rs1, rs2, imm);
    end
    check_both("sw", 32'h00112623, 64'h104);

    send_both(32'hFE000EE3, 64'h108);
    checks++;
    if (itype !== 3'd3 || imm !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL branch: itype=%0d imm=%h required 3/fffffffc", itype, imm);
    end
    check_both("branch", 32'hFE000EE3, 64'h108);

    send_both(32'hFF9FF06F, 64'hFFFF_0000_0000_010C);
    checks++;
    if (w_itype !== 3'd5 || w_imm !== 64'hFFFFFFFFFFFFFFF8) begin
      errors++; $display("FAIL jal64: itype=%0d imm=%h required 5/fffffffffffffff8", w_itype, w_imm);
    end
    check_both("jal", 32'hFF9FF06F, 64'hFFFF_0000_0000_010C);

    send_both(32'h800002B7, 64'h110);
    checks++;
    if (w_itype !== 3'd4 || w_imm !== 64'hFFFFFFFF80000000) begin
      errors++; $display("FAIL lui64: itype=%0d imm=%h required 4/ffffffff80000000", w_itype, w_imm);
    end
    check_both("lui", 32'h800002B7, 64'h110);

    send_both(32'hFFF0009B, 64'h114);
    checks++;
    if (itype !== 3'd0 || w_itype !== 3'd1) begin
      errors++; $display("FAIL addiw_class: x32=%0d x64=%0d required 0/1", itype, w_itype);
    end
    check_both("addiw", 32'hFFF0009B, 64'h114);

    send_both(32'h00000000, 64'h118);
    checks++;
`ifdef DECODE_ILLEGAL_CHECK_EN
    if (illegal !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_illegal: illegal=%b valid=%b required 1/1", illegal, out_valid);
    end
`else
    if (illegal !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_illegal: illegal=%b valid=%b required 0/1", illegal, out_valid);
    end
`endif
    check_both("zero", 32'h00000000, 64'h118);

    send_both(32'h00000013, 64'h11C);
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL nop_illegal: illegal=%b required 0", illegal);
    end
    check_both("nop", 32'h00000013, 64'h11C);

    send_both(32'hFFFFFFFF, 64'h120);
    check_both("ones", 32'hFFFFFFFF, 64'h120);
  endtask

  task automatic test_decode_random();
    logic [31:0] instr;
    logic [63:0] pc;
    for (int i = 0; i < 60; i++) begin
      instr = rand_instr();
      pc    = {$urandom, $urandom};
      send_both(instr, pc);
      check_both("rand_decode", instr, pc);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_c0: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_c1: valid=%b pc=%h in_ready=%b required 1/0/1", out_valid, out_pc, in_ready);
    end
    in_pc = 32'h4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL b2b_c2: in_ready=%b pc=%h required 0/0", in_ready, out_pc);
    end
    in_pc = 32'h8;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL b2b_c3: in_ready=%b valid=%b pc=%h required 0/1/0", in_ready, out_valid, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_c4: valid=%b pc=%h in_ready=%b required 1/4/1", out_valid, out_pc, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
      errors++; $display("FAIL b2b_c5: valid=%b pc=%h required 1/8", out_valid, out_pc);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_c6: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush_full();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h10;
    @(negedge clk);
    in_pc = 32'h14;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full_pre: in_ready=%b valid=%b required 0/1", in_ready, out_valid);
    end
    in_pc = 32'h18; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak: valid=%b pc=%h required valid 0", out_valid, out_pc);
      end
    end
  endtask

  typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;

  task automatic test_random_traffic(input int cycles);
    item_t q[$];
    item_t it;
    bit    exp_valid, exp_ready;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      checks++;
      if (out_valid !== exp_valid || in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_flow c%0d: valid=%b in_ready=%b required %b/%b",
                           c, out_valid, in_ready, exp_valid, exp_ready);
      end
      if (exp_valid) begin
        checks++;
        if (obs32 !== exp32(q[0].instr, q[0].pc)) begin
          errors++; $display("FAIL rand_data c%0d: got %h required %h", c, obs32,
                             exp32(q[0].instr, q[0].pc));
        end
      end
      in_valid  = ($urandom_range(0, 99) < 60);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          it.instr = in_instr; it.pc = in_pc;
          q.push_back(it);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h20;
    @(negedge clk);
    in_pc = 32'h24;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_full_pre: in_ready=%b valid=%b required 0/1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || obs32 !== '0) begin
      errors++; $display("FAIL rst_full: valid=%b in_ready=%b data=%h required 0/0/0", out_valid, in_ready, obs32);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_full_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_flush = 1'b0; w_out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_decode_random();
    test_back_to_back();
    test_flush_full();
    test_random_traffic(2000);
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
